mc_controller_hs: RTL and testbench
===================================

# mc_controller_hs

Parametrised multicycle MIPS control unit: the successor to the fixed-latency controller. It adds a memory request/ready handshake, a bus watchdog, and an extended instruction set (bne, andi, ori, slti, jal). It also keeps an instruction-retired counter. It sits between the instruction register and the multicycle datapath, and it drives every datapath select and enable from a Moore state machine.

## Interface
- `WDOG_CYCLES`, default 16: maximum consecutive wait cycles per memory access; 0 disables the watchdog.
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `op` in 6: instr[31:26], taken from the instruction register.
- `funct` in 6: instr[5:0].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completed the current access this cycle.
- `mem_req` out 1: memory access request.
- `memwrite` out 1: the request is a write.
- `iord` out 1: address select, 0 = pc, 1 = aluout.
- `irwrite` out 1: instruction register load.
- `pcen` out 1: PC load enable.
- `regwrite` out 1: register file write.
- `regdst` out 2: write-register select, 00 = rt, 01 = rd, 10 = r31.
- `memtoreg` out 2: write-data select, 00 = aluout, 01 = data, 10 = pc.
- `alusrca` out 1: ALU A select, 0 = pc, 1 = A.
- `alusrcb` out 2: ALU B select, 00 = B, 01 = 4, 10 = imm, 11 = imm<<2.
- `extop` out 1: immediate extension, 0 = sign, 1 = zero.
- `pcsrc` out 2: PC source, 00 = ALU result, 01 = aluout, 10 = jump target.
- `alucontrol` out 3: ALU operation, 010 = add, 110 = sub, 000 = and, 001 = or, 111 = slt.
- `illegal_op` out 1: one-cycle pulse on an undecoded op or funct.
- `bus_error` out 1: sticky watchdog-expiry flag.
- `retired` out CNT_W: count of completed instructions.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXE, RTWB, IMMEXE, IMMWB, BRANCH, JUMP, JAL, ERROR.
- All outputs are decoded from state (Moore), with two exceptions:
  - `pcen = pcwrite | (branch & (zero ^ is_bne))`.
  - FETCH `irwrite` and `pcwrite` are gated by `mem_ready`.
- FETCH
  - Outputs: `mem_req=1`, `iord=0`, `alusrca=0`, `alusrcb=01`, add, `pcsrc=00`.
  - Stays in FETCH while `mem_ready=0`.
  - On `mem_ready`: IR and PC load, then go to DECODE.
- DECODE
  - Outputs: `alusrcb=11`, add (computes the branch target).
  - Next state by op:
    - 000000 → RTEXE
    - 100011 (lw) and 101011 (sw) → MEMADR
    - 000100 (beq) and 000101 (bne) → BRANCH
    - 001000 (addi), 001010 (slti), 001100 (andi), 001101 (ori) → IMMEXE
    - 000010 → JUMP
    - 000011 → JAL
    - any other op: pulse `illegal_op` and go to FETCH (instruction skipped, not retired).
- MEMADR: `alusrca=1`, `alusrcb=10`, add. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: `mem_req=1`, `iord=1`. Waits for `mem_ready`, then goes to MEMWB.
- MEMWB: `regwrite=1`, `regdst=00`, `memtoreg=01`.
- MEMWR: `mem_req=1`, `memwrite=1`, `iord=1`. Retires on `mem_ready`.
- RTEXE: `alusrca=1`, `alusrcb=00`; `alucontrol` from funct:
  - 100000 → add, 100010 → sub, 100100 → and, 100101 → or, 101010 → slt.
  - Any other funct: `illegal_op` pulse, then go to FETCH without writeback.
- RTWB: `regwrite=1`, `regdst=01`, `memtoreg=00`.
- IMMEXE: `alusrca=1`, `alusrcb=10`.
  - Operation: add for addi, slt for slti, and for andi, or for ori.
  - `extop=1` for andi and ori only.
- IMMWB: `regwrite=1`, `regdst=00`.
- BRANCH: `alusrca=1`, `alusrcb=00`, sub, `branch=1`, `pcsrc=01`.
- JUMP: `pcwrite=1`, `pcsrc=10`.
- JAL: `pcwrite=1`, `pcsrc=10`, `regwrite=1`, `regdst=10`, `memtoreg=10`. Writes the PC already incremented in FETCH to r31.
- After each of MEMWB, RTWB, IMMWB, BRANCH, JUMP, JAL, and a completed MEMWR:
  - `retired` increments, wrapping modulo 2^CNT_W.
  - The state returns to FETCH.
- Watchdog (FETCH, MEMRD, MEMWR only):
  - A counter of width `$clog2(WDOG_CYCLES+1)` counts consecutive cycles with `mem_req=1` and `mem_ready=0`.
  - It clears on `mem_ready` and on any state change.
  - When the count reaches `WDOG_CYCLES`, go to ERROR.
- ERROR: `bus_error=1`; all enables and `mem_req` are 0; stays there until reset.

## Timing
- Reset (async assert, sync deassert at the next clock edge): state FETCH, `retired=0`, `bus_error=0`, watchdog count 0.
- Outputs while in reset equal the FETCH decode with `mem_ready=0`:
  - `mem_req=1`, `alusrcb=01`, `alucontrol=010`, all other outputs 0.
- Cycles per instruction with zero-wait memory: lw 5, sw 4, R-type 4, immediate 4, beq/bne 3, j 3, jal 3.
- Each wait cycle on memory adds 1 cycle.
- `mem_ready` is sampled only in FETCH, MEMRD and MEMWR; it is ignored elsewhere.
- A `mem_ready` arriving in the same cycle the watchdog would expire counts as success.
- Reset asserted mid-instruction abandons the instruction; it is not retired.

## Structure
- Shared package `mips_mc_pkg` holds:
  - the state enum;
  - opcode and funct constants;
  - ALU codes;
  - regdst, memtoreg, alusrcb and pcsrc select encodings.
- One sub-module, `mc_aludec`: combinational mapping of (state class, op, funct) to `alucontrol` plus the funct-illegal flag.

## Test plan
- Zero-wait add $3,$1,$2 (op 000000, funct 100000):
  - FETCH→DECODE→RTEXE→RTWB→FETCH in 4 cycles.
  - `regdst=01`, `alucontrol=010` in RTEXE.
  - `retired` goes 0→1.
- lw with `mem_ready` low for 3 cycles in MEMRD:
  - 8 cycles total, `iord=1` throughout MEMRD.
  - `memtoreg=01` in MEMWB.
- bne with `zero=0`, then with `zero=1`: `pcen=1` in BRANCH only in the first case; `pcsrc=01` in both.
- jal: `regdst=10`, `memtoreg=10`, `pcen=1`, `pcsrc=10` in JAL.
- Op 111111: `illegal_op` pulses in DECODE, then FETCH; `retired` unchanged.
- `WDOG_CYCLES=4` with `mem_ready` held low in FETCH:
  - ERROR entered after 4 wait cycles, `bus_error=1`, `mem_req=0`.
  - Recovery only after `reset` is driven low.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// rtl/mips_mc_pkg.sv - shared encodings for the handshaked multicycle MIPS controller
package mips_mc_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH  = 4'd0;
    localparam state_t S_DECODE = 4'd1;
    localparam state_t S_MEMADR = 4'd2;
    localparam state_t S_MEMRD  = 4'd3;
    localparam state_t S_MEMWB  = 4'd4;
    localparam state_t S_MEMWR  = 4'd5;
    localparam state_t S_RTEXE  = 4'd6;
    localparam state_t S_RTWB   = 4'd7;
    localparam state_t S_IMMEXE = 4'd8;
    localparam state_t S_IMMWB  = 4'd9;
    localparam state_t S_BRANCH = 4'd10;
    localparam state_t S_JUMP   = 4'd11;
    localparam state_t S_JAL    = 4'd12;
    localparam state_t S_ERROR  = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] REGDST_RT  = 2'b00;
    localparam logic [1:0] REGDST_RD  = 2'b01;
    localparam logic [1:0] REGDST_R31 = 2'b10;

    localparam logic [1:0] M2R_ALU  = 2'b00;
    localparam logic [1:0] M2R_DATA = 2'b01;
    localparam logic [1:0] M2R_PC   = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Which ALU decode applies in the current state.
    typedef enum logic [1:0] {
        ACLS_ADD   = 2'd0,
        ACLS_SUB   = 2'd1,
        ACLS_RTYPE = 2'd2,
        ACLS_IMM   = 2'd3
    } alu_class_t;

    function automatic logic op_is_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_J, OP_JAL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// rtl/mc_aludec.sv - ALU operation select from state class, opcode and funct
module mc_aludec
    import mips_mc_pkg::*;
(
    input  alu_class_t  i_class,
    input  logic [5:0]  i_op,
    input  logic [5:0]  i_funct,
    output logic [2:0]  o_alucontrol,
    output logic        o_funct_illegal
);

    always_comb begin
        o_alucontrol    = ALU_ADD;
        o_funct_illegal = 1'b0;
        case (i_class)
            ACLS_SUB: o_alucontrol = ALU_SUB;
            ACLS_RTYPE: begin
                case (i_funct)
                    F_ADD:   o_alucontrol = ALU_ADD;
                    F_SUB:   o_alucontrol = ALU_SUB;
                    F_AND:   o_alucontrol = ALU_AND;
                    F_OR:    o_alucontrol = ALU_OR;
                    F_SLT:   o_alucontrol = ALU_SLT;
                    default: o_funct_illegal = 1'b1;
                endcase
            end
            ACLS_IMM: begin
                case (i_op)
                    OP_SLTI: o_alucontrol = ALU_SLT;
                    OP_ANDI: o_alucontrol = ALU_AND;
                    OP_ORI:  o_alucontrol = ALU_OR;
                    default: o_alucontrol = ALU_ADD;
                endcase
            end
            default: o_alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller_hs.sv
// rtl/mc_controller_hs.sv - multicycle MIPS control FSM with memory handshake,
// bus watchdog and retired-instruction counter
module mc_controller_hs
    import mips_mc_pkg::*;
#(
    parameter int WDOG_CYCLES = 16,
    parameter int CNT_W       = 32
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             memwrite,
    output logic             iord,
    output logic             irwrite,
    output logic             pcen,
    output logic             regwrite,
    output logic [1:0]       regdst,
    output logic [1:0]       memtoreg,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic             extop,
    output logic [1:0]       pcsrc,
    output logic [2:0]       alucontrol,
    output logic             illegal_op,
    output logic             bus_error,
    output logic [CNT_W-1:0] retired
);

    localparam int WDOG_W = (WDOG_CYCLES > 0) ? $clog2(WDOG_CYCLES + 1) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'((WDOG_CYCLES > 0) ? WDOG_CYCLES - 1 : 0);

    state_t             r_state;
    logic [WDOG_W-1:0]  r_wdog_cnt;
    logic               r_bus_error;
    logic [CNT_W-1:0]   r_retired;

    state_t             w_next_state;
    logic               w_retire;
    logic               w_pcwrite;
    logic               w_branch;
    logic               w_is_bne;
    logic               w_wait;
    logic               w_expire;
    logic               w_op_legal;
    logic               w_funct_illegal;
    alu_class_t         w_alu_class;

    assign w_is_bne   = (op == OP_BNE);
    assign w_op_legal = op_is_legal(op);
    assign w_wait     = mem_req & ~mem_ready;
    // A ready on the final allowed wait cycle wins over expiry because w_wait is then low.
    assign w_expire   = (WDOG_CYCLES > 0) && w_wait && (r_wdog_cnt == WDOG_LAST);

    assign pcen      = w_pcwrite | (w_branch & (zero ^ w_is_bne));
    assign bus_error = r_bus_error;
    assign retired   = r_retired;

    mc_aludec u_aludec (
        .i_class         (w_alu_class),
        .i_op            (op),
        .i_funct         (funct),
        .o_alucontrol    (alucontrol),
        .o_funct_illegal (w_funct_illegal)
    );

    always_comb begin
        w_next_state = r_state;
        w_retire     = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (mem_ready)     w_next_state = S_DECODE;
                else if (w_expire) w_next_state = S_ERROR;
            end
            S_DECODE: begin
                case (op)
                    OP_RTYPE:                           w_next_state = S_RTEXE;
                    OP_LW, OP_SW:                       w_next_state = S_MEMADR;
                    OP_BEQ, OP_BNE:                     w_next_state = S_BRANCH;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:  w_next_state = S_IMMEXE;
                    OP_J:                               w_next_state = S_JUMP;
                    OP_JAL:                             w_next_state = S_JAL;
                    default:                            w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR: w_next_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready)     w_next_state = S_MEMWB;
                else if (w_expire) w_next_state = S_ERROR;
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    w_next_state = S_FETCH;
                    w_retire     = 1'b1;
                end else if (w_expire) begin
                    w_next_state = S_ERROR;
                end
            end
            S_RTEXE:  w_next_state = w_funct_illegal ? S_FETCH : S_RTWB;
            S_IMMEXE: w_next_state = S_IMMWB;
            S_MEMWB, S_RTWB, S_IMMWB, S_BRANCH, S_JUMP, S_JAL: begin
                w_next_state = S_FETCH;
                w_retire     = 1'b1;
            end
            S_ERROR:  w_next_state = S_ERROR;
            default:  w_next_state = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req     = 1'b0;
        memwrite    = 1'b0;
        iord        = 1'b0;
        irwrite     = 1'b0;
        w_pcwrite   = 1'b0;
        w_branch    = 1'b0;
        regwrite    = 1'b0;
        regdst      = REGDST_RT;
        memtoreg    = M2R_ALU;
        alusrca     = 1'b0;
        alusrcb     = SRCB_B;
        extop       = 1'b0;
        pcsrc       = PCSRC_ALU;
        illegal_op  = 1'b0;
        w_alu_class = ACLS_ADD;
        case (r_state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alusrcb   = SRCB_FOUR;
                irwrite   = mem_ready;
                w_pcwrite = mem_ready;
            end
            S_DECODE: begin
                alusrcb    = SRCB_IMMSH;
                illegal_op = ~w_op_legal;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = M2R_DATA;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            S_RTEXE: begin
                alusrca     = 1'b1;
                w_alu_class = ACLS_RTYPE;
                illegal_op  = w_funct_illegal;
            end
            S_RTWB: begin
                regwrite = 1'b1;
                regdst   = REGDST_RD;
            end
            S_IMMEXE: begin
                alusrca     = 1'b1;
                alusrcb     = SRCB_IMM;
                w_alu_class = ACLS_IMM;
                extop       = (op == OP_ANDI) || (op == OP_ORI);
            end
            S_IMMWB: regwrite = 1'b1;
            S_BRANCH: begin
                alusrca     = 1'b1;
                w_alu_class = ACLS_SUB;
                w_branch    = 1'b1;
                pcsrc       = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                w_pcwrite = 1'b1;
                pcsrc     = PCSRC_JUMP;
            end
            S_JAL: begin
                // r31 takes the PC that FETCH already advanced by 4.
                w_pcwrite = 1'b1;
                pcsrc     = PCSRC_JUMP;
                regwrite  = 1'b1;
                regdst    = REGDST_R31;
                memtoreg  = M2R_PC;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_FETCH;
            r_wdog_cnt  <= '0;
            r_bus_error <= 1'b0;
            r_retired   <= '0;
        end else begin
            r_state <= w_next_state;
            if ((w_next_state != r_state) || !w_wait)
                r_wdog_cnt <= '0;
            else
                r_wdog_cnt <= r_wdog_cnt + WDOG_W'(1);
            if (w_next_state == S_ERROR)
                r_bus_error <= 1'b1;
            if (w_retire)
                r_retired <= r_retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mc_controller_hs.sv
// tb/tb_mc_controller_hs.sv - scoreboard bench for mc_controller_hs
module tb_mc_controller_hs;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             mem_req, memwrite, iord, irwrite, pcen, regwrite;
    logic [1:0]       regdst, memtoreg, alusrcb, pcsrc;
    logic             alusrca, extop, illegal_op, bus_error;
    logic [2:0]       alucontrol;
    logic [CNT_W-1:0] retired;
    logic [31:0]      obs_w;

    typedef struct {
        string       tag;
        logic        rdy;
        logic [31:0] w;
    } exp_t;

    exp_t exp_q[$];
    int   ret_q[$];
    int   exp_ret  = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mc_controller_hs #(.WDOG_CYCLES(4), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .memwrite   (memwrite),
        .iord       (iord),
        .irwrite    (irwrite),
        .pcen       (pcen),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .extop      (extop),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .illegal_op (illegal_op),
        .bus_error  (bus_error),
        .retired    (retired)
    );

    assign obs_w = {11'd0, mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg,
                    alusrca, alusrcb, extop, pcsrc, alucontrol, illegal_op, bus_error};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cw(input logic mreq, input logic mw, input logic iod,
                                       input logic irw, input logic pce, input logic rw,
                                       input logic [1:0] rd, input logic [1:0] m2r,
                                       input logic asa, input logic [1:0] asb, input logic ext,
                                       input logic [1:0] ps, input logic [2:0] alu,
                                       input logic ill, input logic be);
        return {11'd0, mreq, mw, iod, irw, pce, rw, rd, m2r, asa, asb, ext, ps, alu, ill, be};
    endfunction

    task automatic push(input string tag, input logic rdy, input logic [31:0] w);
        exp_t e;
        e.tag = tag;
        e.rdy = rdy;
        e.w   = w;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            mem_ready = e.rdy;
            #2;
            check(e.tag, obs_w, e.w);
            @(posedge clk);
            #1;
        end
        if (ret_q.size() > 0)
            check("retired", 32'(retired), 32'(ret_q.pop_front()));
    endtask

    // Issue one instruction: fw wait cycles in FETCH, mw wait cycles in MEMRD/MEMWR.
    task automatic issue(input string nm, input logic [5:0] o, input logic [5:0] f,
                         input logic z, input int fw, input int mw);
        logic [2:0] alu;
        logic       ext;
        logic       ill;
        logic       pce;
        op    = o;
        funct = f;
        zero  = z;
        for (int i = 0; i < fw; i++)
            push({nm, ":fetch_wait"}, 1'b0, cw(1,0,0,0,0,0,2'b00,2'b00,0,2'b01,0,2'b00,3'b010,0,0));
        push({nm, ":fetch"}, 1'b1, cw(1,0,0,1,1,0,2'b00,2'b00,0,2'b01,0,2'b00,3'b010,0,0));
        ill = !(o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b001000,
                          6'b001010, 6'b001100, 6'b001101, 6'b000010, 6'b000011});
        push({nm, ":decode"}, 1'($urandom), cw(0,0,0,0,0,0,2'b00,2'b00,0,2'b11,0,2'b00,3'b010,ill,0));
        if (!ill) begin
            case (o)
                6'b000000: begin
                    case (f)
                        6'b100000: alu = 3'b010;
                        6'b100010: alu = 3'b110;
                        6'b100100: alu = 3'b000;
                        6'b100101: alu = 3'b001;
                        6'b101010: alu = 3'b111;
                        default: begin alu = 3'b010; ill = 1'b1; end
                    endcase
                    push({nm, ":rtexe"}, 1'($urandom), cw(0,0,0,0,0,0,2'b00,2'b00,1,2'b00,0,2'b00,alu,ill,0));
                    if (!ill)
                        push({nm, ":rtwb"}, 1'($urandom), cw(0,0,0,0,0,1,2'b01,2'b00,0,2'b00,0,2'b00,3'b010,0,0));
                end
                6'b100011, 6'b101011: begin
                    push({nm, ":memadr"}, 1'($urandom), cw(0,0,0,0,0,0,2'b00,2'b00,1,2'b10,0,2'b00,3'b010,0,0));
                    for (int i = 0; i <= mw; i++) begin
                        if (o == 6'b100011)
                            push({nm, ":memrd"}, i == mw, cw(1,0,1,0,0,0,2'b00,2'b00,0,2'b00,0,2'b00,3'b010,0,0));
                        else
                            push({nm, ":memwr"}, i == mw, cw(1,1,1,0,0,0,2'b00,2'b00,0,2'b00,0,2'b00,3'b010,0,0));
                    end
                    if (o == 6'b100011)
                        push({nm, ":memwb"}, 1'($urandom), cw(0,0,0,0,0,1,2'b00,2'b01,0,2'b00,0,2'b00,3'b010,0,0));
                end
                6'b000100, 6'b000101: begin
                    pce = (o == 6'b000101) ? !z : z;
                    push({nm, ":branch"}, 1'($urandom), cw(0,0,0,0,pce,0,2'b00,2'b00,1,2'b00,0,2'b01,3'b110,0,0));
                end
                6'b000010:
                    push({nm, ":jump"}, 1'($urandom), cw(0,0,0,0,1,0,2'b00,2'b00,0,2'b00,0,2'b10,3'b010,0,0));
                6'b000011:
                    push({nm, ":jal"}, 1'($urandom), cw(0,0,0,0,1,1,2'b10,2'b10,0,2'b00,0,2'b10,3'b010,0,0));
                default: begin
                    case (o)
                        6'b001010: alu = 3'b111;
                        6'b001100: alu = 3'b000;
                        6'b001101: alu = 3'b001;
                        default:   alu = 3'b010;
                    endcase
                    ext = (o == 6'b001100) || (o == 6'b001101);
                    push({nm, ":immexe"}, 1'($urandom), cw(0,0,0,0,0,0,2'b00,2'b00,1,2'b10,ext,2'b00,alu,0,0));
                    push({nm, ":immwb"}, 1'($urandom), cw(0,0,0,0,0,1,2'b00,2'b00,0,2'b00,0,2'b00,3'b010,0,0));
                end
            endcase
        end
        if (!ill)
            exp_ret++;
        ret_q.push_back(exp_ret);
        drain();
    endtask

    initial begin
        reset     = 1'b0;
        op        = 6'd0;
        funct     = 6'd0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", obs_w, cw(1,0,0,0,0,0,2'b00,2'b00,0,2'b01,0,2'b00,3'b010,0,0));
        check("reset_retired", 32'(retired), 32'd0);
        reset = 1'b1;

        issue("add",  6'b000000, 6'b100000, 1'b0, 0, 0);
        issue("sub",  6'b000000, 6'b100010, 1'b0, 0, 0);
        issue("and",  6'b000000, 6'b100100, 1'b0, 0, 0);
        issue("or",   6'b000000, 6'b100101, 1'b0, 0, 0);
        issue("slt",  6'b000000, 6'b101010, 1'b0, 0, 0);
        issue("badfunct", 6'b000000, 6'b000000, 1'b0, 0, 0);
        issue("lw3",  6'b100011, 6'b000000, 1'b0, 0, 3);
        issue("sw1",  6'b101011, 6'b000000, 1'b0, 0, 1);
        issue("addi", 6'b001000, 6'b000000, 1'b0, 0, 0);
        issue("slti", 6'b001010, 6'b000000, 1'b0, 0, 0);
        issue("andi", 6'b001100, 6'b000000, 1'b0, 0, 0);
        issue("ori",  6'b001101, 6'b000000, 1'b0, 0, 0);
        issue("beq_z1", 6'b000100, 6'b000000, 1'b1, 0, 0);
        issue("beq_z0", 6'b000100, 6'b000000, 1'b0, 0, 0);
        issue("bne_z0", 6'b000101, 6'b000000, 1'b0, 0, 0);
        issue("bne_z1", 6'b000101, 6'b000000, 1'b1, 0, 0);
        issue("j",    6'b000010, 6'b000000, 1'b0, 0, 0);
        issue("jal",  6'b000011, 6'b000000, 1'b0, 0, 0);
        issue("badop", 6'b111111, 6'b000000, 1'b0, 0, 0);
        issue("add_fw2", 6'b000000, 6'b100000, 1'b0, 2, 0);

        // Watchdog expiry in FETCH; ERROR must ignore mem_ready until reset.
        op = 6'b000000;
        for (int i = 0; i < 4; i++)
            push("wdog:fetch_wait", 1'b0, cw(1,0,0,0,0,0,2'b00,2'b00,0,2'b01,0,2'b00,3'b010,0,0));
        for (int i = 0; i < 3; i++)
            push("wdog:error", 1'b1, cw(0,0,0,0,0,0,2'b00,2'b00,0,2'b00,0,2'b00,3'b010,0,1));
        drain();
        check("error_retired", 32'(retired), 32'(exp_ret));

        mem_ready = 1'b0;
        reset     = 1'b0;
        #2;
        check("reset_after_error", obs_w, cw(1,0,0,0,0,0,2'b00,2'b00,0,2'b01,0,2'b00,3'b010,0,0));
        check("retired_after_reset", 32'(retired), 32'd0);
        exp_ret = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        issue("add_post_reset", 6'b000000, 6'b100000, 1'b0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
